// File: rtl/rom_ctrl_feeder_pkg.sv
// rtl/rom_ctrl_feeder_pkg.sv - shared types and constants for the ROM digest feeder
package rom_ctrl_feeder_pkg;

    localparam int KmacDataW = 64;
    localparam int KmacStrbW = 8;

    // Every pair of codes differs in at least three bits, so a single upset cannot
    // turn one legal state into another.
    typedef enum logic [5:0] {
        StNonTop = 6'b000111,
        StFlush  = 6'b011001,
        StTop    = 6'b101010,
        StDone   = 6'b110100,
        StError  = 6'b111111
    } state_e;

    function automatic int vbits(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

    // Low data_width/8 strobe bits set.
    function automatic logic [KmacStrbW-1:0] strb_mask(input int data_width);
        logic [KmacStrbW-1:0] m;
        m = '0;
        for (int i = 0; i < KmacStrbW; i++) begin
            if (i < data_width / 8) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/rom_ctrl_feeder_outreg.sv
// rtl/rom_ctrl_feeder_outreg.sv - one-entry valid/ready output register with last flag
module rom_ctrl_feeder_outreg
    import rom_ctrl_feeder_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 in_valid_i,
    input  logic [KmacDataW-1:0] in_data_i,
    input  logic [KmacStrbW-1:0] in_strb_i,
    input  logic                 in_last_i,
    output logic                 in_ready_o,
    output logic                 out_valid_o,
    output logic [KmacDataW-1:0] out_data_o,
    output logic [KmacStrbW-1:0] out_strb_o,
    output logic                 out_last_o,
    input  logic                 out_ready_i
);

    // Space is available when empty or when the held beat leaves this cycle.
    assign in_ready_o = ~out_valid_o | out_ready_i;

    // Load on accept; payload only changes on a load, so it is stable while stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_strb_o  <= '0;
            out_last_o  <= 1'b0;
        end else if (clr_i) begin
            out_valid_o <= 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            out_valid_o <= 1'b1;
            out_data_o  <= in_data_i;
            out_strb_o  <= in_strb_i;
            out_last_o  <= in_last_i;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/rom_ctrl_digest_feeder.sv
// rtl/rom_ctrl_digest_feeder.sv - streams non-top ROM words to KMAC and captures the top words
module rom_ctrl_digest_feeder
    import rom_ctrl_feeder_pkg::*;
#(
    parameter int  RomDepth    = 16,
    parameter int  RomTopCount = 2,
    parameter int  DataWidth   = 32,
    localparam int AW          = vbits(RomDepth)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [DataWidth-1:0]             rom_data_i,
    input  logic [AW-1:0]                    rom_addr_i,
    input  logic                             rom_vld_i,
    input  logic                             rom_last_nontop_i,
    input  logic                             counter_done_i,
    output logic                             rom_rdy_o,
    output logic                             kmac_valid_o,
    output logic [KmacDataW-1:0]             kmac_data_o,
    output logic [KmacStrbW-1:0]             kmac_strb_o,
    output logic                             kmac_last_o,
    input  logic                             kmac_ready_i,
    input  logic                             kmac_done_i,
    output logic [RomTopCount*DataWidth-1:0] exp_digest_o,
    output logic                             done_o,
    output logic                             error_o
);

    localparam int                   RomNonTopCount = RomDepth - RomTopCount;
    localparam logic [AW-1:0]        NonTopBase     = AW'(RomNonTopCount);
    localparam logic [AW-1:0]        TopSlotLast    = AW'(RomTopCount - 1);
    localparam logic [KmacStrbW-1:0] StrbMask       = strb_mask(DataWidth);

    state_e               state_q;
    logic [AW:0]          exp_addr_q;
    logic                 done_seen_q;
    logic                 top_written_q;
    logic                 rdy;
    logic                 outreg_in_ready;
    logic                 nontop_vld;
    logic                 nontop_acc;
    logic                 addr_mismatch;
    logic                 last_beat_acc;
    logic [AW-1:0]        slot;
    logic                 top_wr;
    logic                 top_last_wr;
    logic                 leave_top;
    logic                 err_event;
    logic [KmacDataW-1:0] beat_data;

    // Zero-extend the ROM word to the KMAC beat width.
    always_comb begin
        beat_data                  = '0;
        beat_data[DataWidth-1:0]   = rom_data_i;
    end

    assign nontop_vld    = rom_vld_i & (state_q == StNonTop);
    assign nontop_acc    = nontop_vld & outreg_in_ready;
    // The extra expected-address bit keeps it from wrapping back onto a legal address.
    assign addr_mismatch = {1'b0, rom_addr_i} != exp_addr_q;
    assign last_beat_acc = kmac_valid_o & kmac_ready_i & kmac_last_o;
    assign slot          = rom_addr_i - NonTopBase;
    assign top_wr        = (state_q == StTop) & rom_vld_i & (rom_addr_i >= NonTopBase);
    assign top_last_wr   = top_wr & (slot == TopSlotLast);
    assign leave_top     = counter_done_i & (top_written_q | top_last_wr)
                         & (kmac_done_i | done_seen_q);

    // ROM-side ready per state; the counter only advances when this is high.
    always_comb begin
        rdy = 1'b0;
        case (state_q)
            StNonTop:      rdy = outreg_in_ready;
            StTop, StDone: rdy = 1'b1;
            default:       rdy = 1'b0;
        endcase
    end

    // Held low during reset so the counter never sees an accept before the feeder is live.
    assign rom_rdy_o = rdy & rst_ni;

    // Sequence violations detected this cycle; StDone is immune.
    always_comb begin
        err_event = 1'b0;
        case (state_q)
            StNonTop: err_event = counter_done_i | kmac_done_i | (nontop_acc & addr_mismatch);
            StFlush:  err_event = counter_done_i | (kmac_done_i & ~last_beat_acc);
            StTop:    err_event = rom_vld_i & (rom_addr_i < NonTopBase);
            StDone, StError: err_event = 1'b0;
            default:  err_event = 1'b1;
        endcase
    end

    rom_ctrl_feeder_outreg u_outreg (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (err_event),
        .in_valid_i  (nontop_vld),
        .in_data_i   (beat_data),
        .in_strb_i   (StrbMask),
        .in_last_i   (rom_last_nontop_i),
        .in_ready_o  (outreg_in_ready),
        .out_valid_o (kmac_valid_o),
        .out_data_o  (kmac_data_o),
        .out_strb_o  (kmac_strb_o),
        .out_last_o  (kmac_last_o),
        .out_ready_i (kmac_ready_i)
    );

    // Main sequencer: stream, flush the last beat, collect top words, then finish.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StNonTop;
            exp_addr_q    <= '0;
            done_seen_q   <= 1'b0;
            top_written_q <= 1'b0;
            done_o        <= 1'b0;
            error_o       <= 1'b0;
        end else if (err_event) begin
            state_q <= StError;
            error_o <= 1'b1;
            done_o  <= 1'b0;
        end else begin
            case (state_q)
                StNonTop: begin
                    if (nontop_acc) begin
                        exp_addr_q <= exp_addr_q + 1'b1;
                        if (rom_last_nontop_i) begin
                            state_q <= StFlush;
                        end
                    end
                end
                StFlush: begin
                    if (last_beat_acc) begin
                        state_q <= StTop;
                        if (kmac_done_i) begin
                            done_seen_q <= 1'b1;
                        end
                    end
                end
                StTop: begin
                    if (kmac_done_i) begin
                        done_seen_q <= 1'b1;
                    end
                    if (top_last_wr) begin
                        top_written_q <= 1'b1;
                    end
                    if (leave_top) begin
                        state_q <= StDone;
                        done_o  <= 1'b1;
                    end
                end
                StDone, StError: begin
                end
                default: state_q <= StError;
            endcase
        end
    end

    // Top-word capture; repeated writes to a slot while the counter stalls are harmless.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exp_digest_o <= '0;
        end else if (top_wr) begin
            for (int k = 0; k < RomTopCount; k++) begin
                if (slot == AW'(k)) begin
                    exp_digest_o[k*DataWidth +: DataWidth] <= rom_data_i;
                end
            end
        end
    end

endmodule
